// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, FSM states,
// the ERET exception code and the reset level.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IBUS = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic        RstEna   = 1'b0;

    // A pending exception suppresses every stall so the flush can proceed.
    function automatic logic [5:0] stall_merge(
        input logic        exc_pending,
        input logic        req_mem,
        input logic        req_ex,
        input logic        req_id,
        input logic        ibus_busy
    );
        logic [5:0] v;
        v = STALL_NONE;
        if (exc_pending)    v = STALL_NONE;
        else if (req_mem)   v = STALL_MEM;
        else if (req_ex)    v = STALL_EX;
        else if (req_id)    v = STALL_ID;
        else if (ibus_busy) v = STALL_IBUS;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturating at LIMIT,
// and raises a sticky timeout flag when the count reaches LIMIT.
module stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic timeout
);

    localparam int             CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_flag;
    logic          w_flag_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!stall_active) begin
            w_cnt_next = '0;
        end else if (r_cnt != LIMIT_C) begin
            w_cnt_next = r_cnt + CW'(1);
        end
        w_flag_next = r_flag | (w_cnt_next == LIMIT_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEna) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_flag <= w_flag_next;
        end
    end

    assign timeout = r_flag;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences exception/ERET flushes
// with PC redirect, and runs a stall watchdog. Optional PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          WDOG_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_busy_i,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_count
`endif
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

    ctrl_state_e r_state;
    ctrl_state_e w_state_next;
    logic        r_flush;
    logic        w_flush_next;
    logic [31:0] r_new_pc;
    logic [31:0] w_new_pc_next;
    logic [3:0]  r_flush_cnt;
    logic [3:0]  w_flush_cnt_next;
    logic [5:0]  w_stall;
    logic        w_exc;

    assign w_exc = (excepttype_i != 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEna) begin
            r_state     <= CTRL_RUN;
            r_flush     <= 1'b0;
            r_new_pc    <= 32'd0;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush     <= w_flush_next;
            r_new_pc    <= w_new_pc_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // r_flush_cnt counts flush cycles already started; the entry edge starts the first.
    always_comb begin
        w_state_next     = r_state;
        w_flush_next     = r_flush;
        w_new_pc_next    = r_new_pc;
        w_flush_cnt_next = r_flush_cnt;
        w_stall          = STALL_NONE;
        case (r_state)
            CTRL_RUN: begin
                w_stall = stall_merge(w_exc, stallreq_mem, stallreq_ex,
                                      stallreq_id, ibus_busy_i);
                if (w_exc) begin
                    w_state_next     = CTRL_FLUSH;
                    w_flush_next     = 1'b1;
                    w_flush_cnt_next = 4'd1;
                    w_new_pc_next    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                end
            end
            CTRL_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_next     = CTRL_RUN;
                    w_flush_next     = 1'b0;
                    w_flush_cnt_next = 4'd0;
                end else begin
                    w_flush_cnt_next = r_flush_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = CTRL_RUN;
                w_flush_next = 1'b0;
            end
        endcase
    end

    assign stall  = w_stall;
    assign flush  = r_flush;
    assign new_pc = r_new_pc;

    stall_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (w_stall != STALL_NONE),
        .timeout      (stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEna) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 16'd0;
        end else begin
            if (w_stall != STALL_NONE) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((r_state == CTRL_RUN) && (w_state_next == CTRL_FLUSH)) begin
                r_perf_flush <= r_perf_flush + 16'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, WDOG_LIMIT=8).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        ibus_busy_i;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_count;
`endif

    int checks_cnt;
    int fail_cnt;

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .FLUSH_CYCLES (2),
        .WDOG_LIMIT   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ibus_busy_i   (ibus_busy_i),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excepttype_i  (excepttype_i),
        .cp0_epc_i     (cp0_epc_i),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timer: simulation did not finish, got 0 expected 1");
        $fatal(1, "time limit");
    end

    initial begin
        checks_cnt   = 0;
        fail_cnt     = 0;
        rst          = 1'b0;
        ibus_busy_i  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excepttype_i = 32'd0;
        cp0_epc_i    = 32'd0;

        #12;
        check("rst_stall",   32'(stall), 32'h0);
        check("rst_flush",   32'(flush), 32'h0);
        check("rst_new_pc",  new_pc, 32'h0);
        check("rst_timeout", 32'(stall_timeout), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rel_stall", 32'(stall), 32'h0);
        check("rel_flush", 32'(flush), 32'h0);

        // ID + ibus together for three cycles: ID wins
        stallreq_id = 1'b1;
        ibus_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("id_ibus_c%0d", i), 32'(stall), 32'h07);
            check($sformatf("id_ibus_fl%0d", i), 32'(flush), 32'h0);
            @(negedge clk);
        end
        stallreq_id = 1'b0;
        ibus_busy_i = 1'b0;
        #1 check("ibus_off", 32'(stall), 32'h0);

        // exception together with MEM stall, held through flush
        @(negedge clk);
        excepttype_i = 32'h8;
        stallreq_mem = 1'b1;
        #1 check("exc_stall", 32'(stall), 32'h0);
        check("exc_pre_flush", 32'(flush), 32'h0);
        @(negedge clk);
        check("exc_flush1", 32'(flush), 32'h1);
        check("exc_pc1", new_pc, 32'h20);
        check("exc_fstall1", 32'(stall), 32'h0);
        @(negedge clk);
        check("exc_flush2", 32'(flush), 32'h1);
        check("exc_pc2", new_pc, 32'h20);
        excepttype_i = 32'h0;
        #1 check("flush_ignores_mem", 32'(stall), 32'h0);
        @(negedge clk);
        check("exc_done_flush", 32'(flush), 32'h0);
        check("run_mem_stall", 32'(stall), 32'h1f);
        stallreq_mem = 1'b0;

        // ERET redirects to EPC
        @(negedge clk);
        excepttype_i = 32'he;
        cp0_epc_i    = 32'h0000_1234;
        @(negedge clk);
        excepttype_i = 32'h0;
        check("eret_flush", 32'(flush), 32'h1);
        check("eret_pc", new_pc, 32'h0000_1234);
        @(negedge clk);
        check("eret_flush2", 32'(flush), 32'h1);
        @(negedge clk);
        check("eret_done", 32'(flush), 32'h0);

        // watchdog: EX stall held for eight cycles
        stallreq_ex = 1'b1;
        #1 check("ex_stall", 32'(stall), 32'h0f);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("wdog_c%0d", i), 32'(stall_timeout), (i >= 8) ? 32'h1 : 32'h0);
        end
        stallreq_ex = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wdog_sticky", 32'(stall_timeout), 32'h1);

        // reset asserted in the middle of a flush
        excepttype_i = 32'h8;
        @(negedge clk);
        check("mid_flush", 32'(flush), 32'h1);
        #2 rst = 1'b0;
        excepttype_i = 32'h0;
        #1;
        check("arst_flush",   32'(flush), 32'h0);
        check("arst_stall",   32'(stall), 32'h0);
        check("arst_new_pc",  new_pc, 32'h0);
        check("arst_timeout", 32'(stall_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_flush", 32'(flush), 32'h0);
        stallreq_id = 1'b1;
        #1 check("post_rst_run", 32'(stall), 32'h07);
        stallreq_id = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
